// File: rtl/reg_bank_slave.sv
// Bus-mapped register bank behind uart_core: ID, scratch, counter with
// coherent HI/LO snapshot, data FIFO, sticky read-clear status flags.
module reg_bank_slave #(
  parameter logic [15:0] ID_VALUE   = 16'h5A01,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst_n,
  input  logic [15:0] bus2ip_addr_i,
  input  logic [15:0] bus2ip_data_i,
  input  logic        bus2ip_rd_ce_i,
  input  logic        bus2ip_wr_ce_i,
  output logic [15:0] ip2bus_data_o,
  output logic        fifo_nempty_o
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;
  localparam int unsigned LW = FIFO_AW + 1;

  localparam logic [DW-1:0] ADDR_ID       = 16'h0000;
  localparam logic [DW-1:0] ADDR_SCRATCH0 = 16'h0001;
  localparam logic [DW-1:0] ADDR_SCRATCH1 = 16'h0002;
  localparam logic [DW-1:0] ADDR_CTRL     = 16'h0003;
  localparam logic [DW-1:0] ADDR_CNT_LO   = 16'h0004;
  localparam logic [DW-1:0] ADDR_CNT_HI   = 16'h0005;
  localparam logic [DW-1:0] ADDR_FIFO     = 16'h0006;
  localparam logic [DW-1:0] ADDR_STATUS   = 16'h0007;
  localparam logic [DW-1:0] ADDR_ACC_CNT  = 16'h0008;
  localparam logic [DW-1:0] BAD_ADDR_DATA = 16'hDEAD;

  logic [DW-1:0]      scratch0_q, scratch0_d;
  logic [DW-1:0]      scratch1_q, scratch1_d;
  logic               cnt_en_q, cnt_en_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      cnt_hi_snap_q, cnt_hi_snap_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               addr_err_q, addr_err_d;
  logic [DW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               nempty_q, nempty_d;

  logic [DW-1:0]      mem_q [FIFO_DEPTH];

  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic               push_c;
  logic               pop_c;
  logic               ovf_set_c;
  logic               unf_set_c;
  logic               err_set_c;
  logic               sts_clr_c;
  logic [DW-1:0]      status_c;

  assign fifo_full_c  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty_c = (level_q == '0);
  assign status_c     = {3'b000, addr_err_q, unf_q, ovf_q,
                         fifo_full_c, fifo_empty_c, 8'(level_q)};

  // Access decode and next-state computation
  always_comb begin
    scratch0_d    = scratch0_q;
    scratch1_d    = scratch1_q;
    cnt_en_d      = cnt_en_q;
    cnt_d         = cnt_en_q ? cnt_q + CW'(1) : cnt_q;
    cnt_hi_snap_d = cnt_hi_snap_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    acc_cnt_d     = acc_cnt_q;
    rdata_d       = rdata_q;
    push_c        = 1'b0;
    pop_c         = 1'b0;
    ovf_set_c     = 1'b0;
    unf_set_c     = 1'b0;
    err_set_c     = 1'b0;
    sts_clr_c     = 1'b0;

    if (bus2ip_rd_ce_i || bus2ip_wr_ce_i) begin
      acc_cnt_d = acc_cnt_q + DW'(1);
    end

    if (bus2ip_wr_ce_i) begin
      case (bus2ip_addr_i)
        ADDR_SCRATCH0: scratch0_d = bus2ip_data_i;
        ADDR_SCRATCH1: scratch1_d = bus2ip_data_i;
        ADDR_CTRL: begin
          cnt_en_d = bus2ip_data_i[0];
          if (bus2ip_data_i[1]) begin
            cnt_d = '0;
          end
        end
        ADDR_FIFO: begin
          if (fifo_full_c) begin
            ovf_set_c = 1'b1;
          end else begin
            push_c = 1'b1;
          end
        end
        ADDR_ID, ADDR_CNT_LO, ADDR_CNT_HI, ADDR_STATUS, ADDR_ACC_CNT: begin
        end
        default: err_set_c = 1'b1;
      endcase
    end

    // A read that collides with a write is dropped and flagged
    if (bus2ip_rd_ce_i && bus2ip_wr_ce_i) begin
      err_set_c = 1'b1;
    end else if (bus2ip_rd_ce_i) begin
      case (bus2ip_addr_i)
        ADDR_ID:       rdata_d = ID_VALUE;
        ADDR_SCRATCH0: rdata_d = scratch0_q;
        ADDR_SCRATCH1: rdata_d = scratch1_q;
        ADDR_CTRL:     rdata_d = {15'd0, cnt_en_q};
        ADDR_CNT_LO: begin
          rdata_d       = cnt_q[DW-1:0];
          cnt_hi_snap_d = cnt_q[CW-1:DW];
        end
        ADDR_CNT_HI:   rdata_d = cnt_hi_snap_q;
        ADDR_FIFO: begin
          if (fifo_empty_c) begin
            rdata_d   = '0;
            unf_set_c = 1'b1;
          end else begin
            rdata_d = mem_q[rd_ptr_q];
            pop_c   = 1'b1;
          end
        end
        ADDR_STATUS: begin
          rdata_d   = status_c;
          sts_clr_c = 1'b1;
        end
        ADDR_ACC_CNT:  rdata_d = acc_cnt_q;
        default: begin
          rdata_d   = BAD_ADDR_DATA;
          err_set_c = 1'b1;
        end
      endcase
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    if (push_c && !pop_c) begin
      level_d = level_q + LW'(1);
    end else if (pop_c && !push_c) begin
      level_d = level_q - LW'(1);
    end

    // Set events beat the read-clear
    ovf_d      = ovf_set_c | (ovf_q & ~sts_clr_c);
    unf_d      = unf_set_c | (unf_q & ~sts_clr_c);
    addr_err_d = err_set_c | (addr_err_q & ~sts_clr_c);
    nempty_d   = (level_d != '0);
  end

  always_ff @(posedge bus2ip_clk) begin
    if (!bus2ip_rst_n) begin
      scratch0_q    <= '0;
      scratch1_q    <= '0;
      cnt_en_q      <= 1'b0;
      cnt_q         <= '0;
      cnt_hi_snap_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      addr_err_q    <= 1'b0;
      acc_cnt_q     <= '0;
      rdata_q       <= '0;
      nempty_q      <= 1'b0;
    end else begin
      scratch0_q    <= scratch0_d;
      scratch1_q    <= scratch1_d;
      cnt_en_q      <= cnt_en_d;
      cnt_q         <= cnt_d;
      cnt_hi_snap_q <= cnt_hi_snap_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      addr_err_q    <= addr_err_d;
      acc_cnt_q     <= acc_cnt_d;
      rdata_q       <= rdata_d;
      nempty_q      <= nempty_d;
    end
  end

  // FIFO storage needs no reset; the pointers and level define validity
  always_ff @(posedge bus2ip_clk) begin
    if (push_c && bus2ip_rst_n) begin
      mem_q[wr_ptr_q] <= bus2ip_data_i;
    end
  end

  assign ip2bus_data_o = rdata_q;
  assign fifo_nempty_o = nempty_q;

endmodule
